plot_fb_writer: RTL



---
 rtl/plot_pkg.sv | 16 +
 rtl/plot_fb_writer_if.sv | 36 +++
 rtl/plot_fifo.sv | 47 ++++
 rtl/plot_fb_writer.sv | 80 ++++++++
 4 files changed

// File: rtl/plot_pkg.sv
// plot_pkg: shared widths, address helper, FSM states and pixel entry type for the framebuffer writer (PLOT_ERASE_EN adds the erase flag)
package plot_pkg;
    localparam int X_BITS_DEF = 8;
    localparam int Y_BITS_DEF = 8;
    typedef enum logic {IDLE, MOD} state_t;
    function automatic int addr_bits(input int xb, input int yb);
        return yb + xb - 3;
    endfunction
    typedef struct packed {
`ifdef PLOT_ERASE_EN
        logic erase;
`endif
        logic [Y_BITS_DEF-1:0] y;
        logic [X_BITS_DEF-1:0] x;
    } pixel_t;
endpackage

// File: rtl/plot_fb_writer_if.sv
// plot_fb_writer_if: pixel stream, status and framebuffer RAM port bundle (PLOT_ERASE_EN adds erase)
interface plot_fb_writer_if #(
    parameter int X_BITS = 8,
    parameter int Y_BITS = 8
);
    import plot_pkg::*;
    localparam int A_BITS = addr_bits(X_BITS, Y_BITS);
    logic              plot;
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
`ifdef PLOT_ERASE_EN
    logic              erase;
`endif
    logic              ready;
    logic              busy;
    logic              overflow;
    logic [A_BITS-1:0] mem_addr;
    logic              mem_re;
    logic [7:0]        mem_rdata;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    modport master (
`ifdef PLOT_ERASE_EN
        output erase,
`endif
        output plot, x, y, mem_rdata,
        input  ready, busy, overflow, mem_addr, mem_re, mem_we, mem_wdata
    );
    modport slave (
`ifdef PLOT_ERASE_EN
        input  erase,
`endif
        input  plot, x, y, mem_rdata,
        output ready, busy, overflow, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/plot_fifo.sv
// plot_fifo: synchronous FIFO with registered occupancy count and wrapping pointers
module plot_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int P = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [P-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [P:0]       cnt_q, cnt_d;
    logic             do_push, do_pop;
    // Qualify requests against the registered flags and advance pointers/count.
    always_comb begin
        full    = cnt_q == (P+1)'(DEPTH);
        empty   = cnt_q == '0;
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = wr_q + P'(do_push);
        rd_d    = rd_q + P'(do_pop);
        cnt_d   = cnt_q + (P+1)'(do_push) - (P+1)'(do_pop);
        dout    = mem_q[rd_q];
    end
    // Pointer and count state; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    // Entry storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/plot_fb_writer.sv
// plot_fb_writer: buffers plotted pixels and read-modify-writes them into a 1bpp byte-wide framebuffer (PLOT_ERASE_EN enables pixel erase)
module plot_fb_writer
    import plot_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int X_BITS     = X_BITS_DEF,
    parameter int Y_BITS     = Y_BITS_DEF
) (
    input logic              clk,
    input logic              reset,
    plot_fb_writer_if.slave  bus
);
    typedef struct packed {
`ifdef PLOT_ERASE_EN
        logic erase;
`endif
        logic [Y_BITS-1:0] y;
        logic [X_BITS-1:0] x;
    } entry_t;
    state_t state_q, state_d;
    entry_t pix_q, pix_d, head, din;
    logic   overflow_q, overflow_d;
    logic   full, empty, ready, push, pop, set_bit;
    logic [7:0] mask;
    plot_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    // Handshake: accept while not full and out of reset; pop whenever the FSM starts a pixel.
    always_comb begin
        ready = !full && !reset;
        push  = bus.plot && ready;
        pop   = state_q == IDLE && !empty;
        din.x = bus.x;
        din.y = bus.y;
`ifdef PLOT_ERASE_EN
        din.erase = bus.erase;
`endif
    end
    // State, latched pixel and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pix_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            overflow_q <= overflow_d;
        end
    end
    // Next state: IDLE issues the read when work is queued, MOD always writes back and returns.
    always_comb begin
        state_d    = pop ? MOD : IDLE;
        pix_d      = pop ? head : pix_q;
        overflow_d = overflow_q || (bus.plot && !ready);
    end
    // RAM port: read addressed by the FIFO head in IDLE, write of the modified byte in MOD.
    always_comb begin
        mask = 8'h01 << pix_q.x[2:0];
`ifdef PLOT_ERASE_EN
        set_bit = !pix_q.erase;
`else
        set_bit = 1'b1;
`endif
        bus.ready     = ready;
        bus.busy      = !reset && (!empty || state_q != IDLE);
        bus.overflow  = overflow_q;
        bus.mem_re    = !reset && pop;
        bus.mem_we    = !reset && state_q == MOD;
        bus.mem_addr  = reset ? '0 : pop ? {head.y, head.x[X_BITS-1:3]} : {pix_q.y, pix_q.x[X_BITS-1:3]};
        bus.mem_wdata = !bus.mem_we ? 8'h00 : set_bit ? (bus.mem_rdata | mask) : (bus.mem_rdata & ~mask);
    end
endmodule
